// File: rtl/perceptron_core_pkg.sv
// Shared definitions for the perceptron core: command opcodes, the FSM state
// encoding (also reported in status[2:0]) and the status bit positions.
package perceptron_core_pkg;

    localparam logic [7:0] OP_LOAD_W = 8'h01;
    localparam logic [7:0] OP_LOAD_X = 8'h02;
    localparam logic [7:0] OP_SEND   = 8'h03;
    localparam logic [7:0] OP_LOAD_B = 8'h04;
    localparam logic [7:0] OP_CLEAR  = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_LOAD_X = 3'd3,
        ST_MAC    = 3'd4,
        ST_SEND   = 3'd5
    } state_t;

    localparam int STAT_ERR  = 7;
    localparam int STAT_SAT  = 6;
    localparam int STAT_BUSY = 5;

endpackage

// File: rtl/perceptron_core_if.sv
// Byte-stream interface of the perceptron core.
//   in_valid/in_data   : received command/payload byte strobe
//   out_busy           : downstream transmitter busy
//   out_valid/out_data : transmit byte strobe
//   fire               : registered perceptron decision
//   status             : {err, sat, busy, 2'b0, state[2:0]}
// master = the side feeding bytes in (host), slave = the core.
interface perceptron_core_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_busy;
    logic       out_valid;
    logic [7:0] out_data;
    logic       fire;
    logic [7:0] status;

    modport master (
        output in_valid, in_data, out_busy,
        input  out_valid, out_data, fire, status
    );

    modport slave (
        input  in_valid, in_data, out_busy,
        output out_valid, out_data, fire, status
    );
endinterface

// File: rtl/perceptron_mac.sv
// Combinational multiply-accumulate step: signed 8x8 product, sign-extended
// and added to the running accumulator with saturation.
//   w, x     : signed 8-bit operands
//   acc      : current accumulator (signed, ACC_W bits)
//   acc_next : saturated sum
//   ovf      : 1 when the sum was clamped
module perceptron_mac #(
    parameter int ACC_W = 24
) (
    input  logic signed [7:0]       w,
    input  logic signed [7:0]       x,
    input  logic        [ACC_W-1:0] acc,
    output logic        [ACC_W-1:0] acc_next,
    output logic                    ovf
);

    logic signed [15:0] prod;
    logic [ACC_W:0]     sum;

    assign prod = w * x;
    // One guard bit: the sum overflowed when the two top bits disagree.
    assign sum  = {acc[ACC_W-1], acc} + {{(ACC_W-15){prod[15]}}, prod};
    assign ovf  = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        acc_next = sum[ACC_W-1:0];
        if (ovf) begin
            if (sum[ACC_W]) begin
                acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                acc_next = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/perceptron_core.sv
// Byte-command driven perceptron: loads N_IN signed weights, a signed bias and
// N_IN signed inputs, accumulates w[i]*x[i] one term per cycle with saturation,
// decides fire = (acc >= bias) and can stream the accumulator out LSB first.
//   clk  : clock
//   nRst : asynchronous active-low reset
//   bus  : perceptron_core_if.slave (byte in/out strobes, fire, status)
module perceptron_core
    import perceptron_core_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             nRst,
    perceptron_core_if.slave bus
);

    localparam int NB     = ACC_W / 8;
    localparam int CNT_W  = 9;
    localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int BSEL_W = $clog2(NB);
    localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(N_IN - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic signed [7:0] w_reg [N_IN];
    logic signed [7:0] x_reg [N_IN];
    logic [ACC_W-1:0]  bias_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic              fire_reg, sat_reg, err_reg, guard_reg;
    logic              out_valid_reg;
    logic [7:0]        out_data_reg;

    logic              send_go, clear_all, mac_start, mac_last, busy;
    logic [IDX_W-1:0]  idx;
    logic [ACC_W-1:0]  mac_sum;
    logic              mac_ovf;
    logic [NB-1:0][7:0] acc_bytes;
    logic [7:0]        status_w;

    assign idx      = cnt_reg[IDX_W-1:0];
    assign busy     = (state_reg == ST_MAC) || (state_reg == ST_SEND);
    assign mac_last = (state_reg == ST_MAC) && (cnt_reg == LAST_IN);

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_acc_byte
            assign acc_bytes[gi] = acc_reg[gi*8 +: 8];
        end
    endgenerate

    perceptron_mac #(.ACC_W(ACC_W)) u_mac (
        .w        (w_reg[idx]),
        .x        (x_reg[idx]),
        .acc      (acc_reg),
        .acc_next (mac_sum),
        .ovf      (mac_ovf)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and counter. Payload bytes in LOAD_* are never decoded.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        send_go    = 1'b0;
        clear_all  = 1'b0;
        mac_start  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (bus.in_valid) begin
                    case (bus.in_data)
                        OP_LOAD_W: state_next = ST_LOAD_W;
                        OP_LOAD_X: state_next = ST_LOAD_X;
                        OP_SEND:   state_next = ST_SEND;
                        OP_LOAD_B: state_next = ST_LOAD_B;
                        OP_CLEAR:  clear_all  = 1'b1;
                        default:   ;
                    endcase
                end
            end
            ST_LOAD_W: if (bus.in_valid) begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_IN) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD_X: if (bus.in_valid) begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_IN) begin
                    cnt_next   = '0;
                    state_next = ST_MAC;
                    mac_start  = 1'b1;
                end
            end
            ST_LOAD_B: if (bus.in_valid) begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_BYTE) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            ST_MAC: begin
                cnt_next = cnt_reg + 1'b1;
                if (mac_last) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            ST_SEND: begin
                // The cycle after an issue is a guard cycle: out_busy ignored.
                if (!bus.out_busy && !guard_reg) begin
                    send_go  = 1'b1;
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BYTE) begin
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < N_IN; i++) begin
                w_reg[i] <= '0;
                x_reg[i] <= '0;
            end
            bias_reg      <= '0;
            acc_reg       <= '0;
            fire_reg      <= 1'b0;
            sat_reg       <= 1'b0;
            err_reg       <= 1'b0;
            guard_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            out_valid_reg <= send_go;
            guard_reg     <= send_go;
            if (send_go) begin
                out_data_reg <= acc_bytes[cnt_reg[BSEL_W-1:0]];
            end
            if (busy && bus.in_valid) begin
                err_reg <= 1'b1;
            end
            if (state_reg == ST_LOAD_W && bus.in_valid) begin
                w_reg[idx] <= bus.in_data;
            end
            if (state_reg == ST_LOAD_X && bus.in_valid) begin
                x_reg[idx] <= bus.in_data;
            end
            if (state_reg == ST_LOAD_B && bus.in_valid) begin
                for (int i = 0; i < NB; i++) begin
                    if (cnt_reg == CNT_W'(i)) begin
                        bias_reg[i*8 +: 8] <= bus.in_data;
                    end
                end
            end
            if (mac_start) begin
                acc_reg <= '0;
                sat_reg <= 1'b0;
            end
            if (state_reg == ST_MAC) begin
                acc_reg <= mac_sum;
                if (mac_ovf) begin
                    sat_reg <= 1'b1;
                end
                // Decide on the final sum as it is being registered.
                if (mac_last) begin
                    fire_reg <= ($signed(mac_sum) >= $signed(bias_reg));
                end
            end
            if (clear_all) begin
                for (int i = 0; i < N_IN; i++) begin
                    w_reg[i] <= '0;
                end
                bias_reg <= '0;
                acc_reg  <= '0;
                fire_reg <= 1'b0;
                sat_reg  <= 1'b0;
                err_reg  <= 1'b0;
            end
        end
    end

    always_comb begin
        status_w            = '0;
        status_w[STAT_ERR]  = err_reg;
        status_w[STAT_SAT]  = sat_reg;
        status_w[STAT_BUSY] = busy;
        status_w[2:0]       = state_reg;
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.fire      = fire_reg;
    assign bus.status    = status_w;

endmodule

// File: doc/perceptron_core.md
PERCEPTRON_CORE -- requirements
Module: perceptron_core

Interface
REQ-001 Parameter N_IN, default 8: number of inputs/weights, legal 1..256.
REQ-002 Parameter ACC_W, default 24: accumulator/bias width, multiple of 8, legal 16..64.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 nRst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  one-cycle strobe: in_data holds a received byte.
REQ-006 in_data  input  8  command/payload byte.
REQ-007 out_busy  input  1  downstream transmitter busy.
REQ-008 out_valid  output  1  one-cycle strobe: out_data holds a byte to transmit.
REQ-009 out_data  output  8  transmit byte.
REQ-010 fire  output  1  registered perceptron decision.
REQ-011 status  output  8  {err, sat, busy, 2'b0, state[2:0]}.

Function
REQ-012 States IDLE, LOAD_W, LOAD_B, LOAD_X, MAC, SEND; encoded 0..5 in status[2:0].
REQ-013 IDLE: in_valid with opcode 0x01->LOAD_W, 0x02->LOAD_X, 0x03->SEND, 0x04->LOAD_B, 0x05 clears weights, bias, acc, fire, sat, err in one cycle and stays IDLE; any other opcode ignored.
REQ-014 LOAD_W: next N_IN bytes written, as signed 8-bit, to w[0..N_IN-1] in order; after byte N_IN-1 -> IDLE.
REQ-015 LOAD_B: next ACC_W/8 bytes, LSB first, form signed bias; after last byte -> IDLE.
REQ-016 LOAD_X: next N_IN bytes stored, as signed 8-bit, to x[0..N_IN-1]; after last byte -> MAC.
REQ-017 MAC: acc cleared and sat cleared on entry; one product w[i]*x[i] per cycle, i=0..N_IN-1; exactly N_IN cycles in MAC, then -> IDLE.
REQ-018 Product 16-bit signed, sign-extended to ACC_W; sum saturates to +2^(ACC_W-1)-1 / -2^(ACC_W-1); any saturation sets sat (sticky until next MAC entry or 0x05).
REQ-019 fire updated on the MAC->IDLE transition: 1 iff final acc >= bias (signed); held otherwise.
REQ-020 Latency: fire/acc valid N_IN+1 cycles after the cycle last x byte is accepted.
REQ-021 SEND: transmits ACC_W/8 bytes of acc, LSB first; a byte is issued (out_valid=1 one cycle) only when out_busy=0 and not in the guard cycle; after each strobe one guard cycle ignores out_busy; after last strobe -> IDLE.
REQ-022 out_busy held high indefinitely: no strobe, state holds in SEND.
REQ-023 busy=1 in MAC and SEND; in_valid during MAC or SEND drops the byte and sets err (sticky until 0x05 or reset).
REQ-024 Payload bytes in LOAD_* never decoded as opcodes, whatever their value.
REQ-025 out_data holds last sent byte between strobes; 0 after reset.

Reset
REQ-026 nRst low: state IDLE; w, x, bias, acc, counters, fire, sat, err, out_valid, out_data all zero, asynchronously.
REQ-027 Reset mid-MAC or mid-SEND aborts the operation; no further out_valid until a new 0x03.

Structure
REQ-028 Shared package: opcode constants (0x01..0x05), state enum, status bit positions.
REQ-029 One sub-module, perceptron_mac: combinational signed 8x8 multiply plus saturating ACC_W add, outputs next acc and overflow flag; all registers in perceptron_core.

Verification (N_IN=4, ACC_W=24 unless stated)
REQ-030 Reset: after nRst release, out_valid=0, out_data=0x00, fire=0, status=0x00.
REQ-031 0x01,01,02,03,04; 0x04,00,00,00; 0x02,01,01,01,01 -> fire=1 five cycles after last x; 0x03 -> bytes 0x0A,0x00,0x00.
REQ-032 Weights FF,FE,FD,FC, bias 0, x 01,01,01,01 -> fire=0; read -> 0xF6,0xFF,0xFF; sat=0.
REQ-033 ACC_W=16: weights 7F x4, x 7F x4 -> acc 0x7FFF, sat=1; read -> 0xFF,0x7F.
REQ-034 Byte during MAC -> dropped, err=1, result unchanged; READ with out_busy held high 100 cycles -> no out_valid, then release -> three strobes, each separated by guard cycle.
REQ-035 nRst pulsed after first SEND byte -> no further strobes, status=0x00, subsequent read -> 0x00,0x00,0x00.
